jtag_dr_bank: RTL and testbench
===============================

// Module: jtag_dr_bank
// PURPOSE
//  Parametrised DR engine behind the 9-bit virtual-JTAG hub, in the tck domain. Decodes
//  ir_in into BYPASS, IDCODE and NUM_REGS user data registers of DR_WIDTH bits each.
//  Captures readback and shifts LSB-first. Commits writes on update-DR only after a
//  complete shift, flagging partial shifts. Replaces per-register hand-wired shift logic.
// PARAMETERS
//  IR_WIDTH   9             instruction width (matches hub ir_in/ir_out)
//  DR_WIDTH   32            user/IDCODE data register width, >=2
//  NUM_REGS   4             number of user registers, 1..16
//  RO_MASK    {NUM_REGS{0}} bit k=1: register k is read-only (UDR never writes it)
//  ID_VALUE   32'h4A54_0001 IDCODE value, zero-extended/truncated to DR_WIDTH
// PORTS
//  tck                input  1                   clock (JTAG TCK from hub)
//  reset              input  1                   synchronous, active-high
//  tdi                input  1                   serial data in from hub
//  tdo                output 1                   serial data out to hub
//  ir_in              input  IR_WIDTH            current virtual instruction
//  ir_out             output IR_WIDTH            value captured into IR on capture-IR
//  virtual_state_cdr  input  1                   capture-DR
//  virtual_state_sdr  input  1                   shift-DR
//  virtual_state_e1dr input  1                   exit1-DR
//  virtual_state_pdr  input  1                   pause-DR
//  virtual_state_e2dr input  1                   exit2-DR
//  virtual_state_udr  input  1                   update-DR
//  virtual_state_cir  input  1                   capture-IR
//  virtual_state_uir  input  1                   update-IR
//  reg_q              output NUM_REGS*DR_WIDTH   committed register values, reg k at [k*DR_WIDTH+:DR_WIDTH]
//  reg_d              input  NUM_REGS*DR_WIDTH   readback values, captured on CDR
//  wr_pulse           output NUM_REGS            1-cycle strobe: reg k committed
//  rd_pulse           output NUM_REGS            1-cycle strobe: reg k captured
// BEHAVIOUR
//  Decode, from ir_in, sampled every cycle:
//   0x000 BYPASS; 0x001 IDCODE; 0x010+k (k<NUM_REGS) USER k; 0x1FF CLRERR.
//   Any other code = BYPASS plus invalid flag.
//  Reset: sr=0, reg_q=0, wr_pulse=0, rd_pulse=0, tdo=0, err=0, upd_cnt=0, state=IDLE.
//  FSM states: IDLE, CAPT, SHIFT, DONE.
//   IDLE --cdr--> CAPT.
//   CAPT/SHIFT --sdr--> SHIFT, bit_cnt++ (saturates at DR_WIDTH+1).
//   Any state --udr--> IDLE.
//   cdr in any state restarts at CAPT with bit_cnt=0.
//   e1dr/pdr/e2dr hold sr and bit_cnt unchanged.
//  Capture (cdr), by decode:
//   USER k: sr<=reg_d[k] and rd_pulse[k]=1 for that cycle.
//   IDCODE: sr<=ID_VALUE.  BYPASS: sr<=0 (1-bit path).
//  Shift (sdr): sr<={tdi,sr[DR_WIDTH-1:1]}; BYPASS uses sr[0]<=tdi only.
//  tdo = sr[0]; combinational from the register, no tdi-to-tdo comb path.
//  Update (udr), USER k with bit_cnt==DR_WIDTH and RO_MASK[k]==0:
//   reg_q[k]<=sr next cycle edge; wr_pulse[k]=1 for exactly 1 cycle (the cycle after udr).
//   upd_cnt++, wrapping modulo 2^(IR_WIDTH-2).
//  Update error cases, all with no write and no pulse:
//   bit_cnt!=DR_WIDTH -> err<=1.
//   RO_MASK[k]==1 -> err<=1.
//  udr while decode is CLRERR -> err<=0.
//  ir_out: on cir, ir_out<={err, invalid, upd_cnt}; otherwise held. Reset value 0.
//   invalid = ir_in was an undefined code at the last uir (registered on uir).
//  Simultaneous sdr+udr (illegal from hub): udr wins and sr is not shifted.
//  Reset mid-shift: all state cleared; reg_q=0 on the cycle after reset.
//  At most one bit of wr_pulse/rd_pulse is high in any cycle.
// TESTING
//  1. reset; IR=0x001; cdr, 32x sdr: tdo sequence = 32'h4A54_0001 LSB first.
//  2. IR=0x012; cdr, shift 32'hDEAD_BEEF, udr:
//     reg_q[2]=DEAD_BEEF, wr_pulse=4'b0100 for 1 cycle, upd_cnt=1.
//  3. IR=0x011; reg_d[1]=32'h1234_5678; cdr: rd_pulse=4'b0010; shifted-out tdo = 1234_5678.
//  4. IR=0x010; 31 sdr then udr: reg_q[0] unchanged, no wr_pulse;
//     cir -> ir_out[8]=1; IR=0x1FF, udr -> next cir ir_out[8]=0.
//  5. RO_MASK=4'b1000; IR=0x013; full 32-bit write: no commit, err=1.
//     IR=0x055 (invalid): 1-bit bypass, tdo=tdi delayed 1 sdr, ir_out[7]=1.
//  6. reset asserted on 10th sdr of a USER write: reg_q=0, no pulse, tdo=0; next full write commits.

Source files
------------

// File: rtl/jtag_dr_bank.sv
// Data-register engine behind the virtual-JTAG hub. It decodes the virtual instruction and
// implements BYPASS, IDCODE, NUM_REGS user registers and CLRERR, all in the tck domain.
module jtag_dr_bank #(
    parameter int                  IR_WIDTH = 9,
    parameter int                  DR_WIDTH = 32,
    parameter int                  NUM_REGS = 4,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
    parameter logic [31:0]         ID_VALUE = 32'h4A54_0001
) (
    input  logic                         tck,
    input  logic                         reset,
    input  logic                         tdi,
    output logic                         tdo,
    input  logic [IR_WIDTH-1:0]          ir_in,
    output logic [IR_WIDTH-1:0]          ir_out,
    input  logic                         virtual_state_cdr,
    input  logic                         virtual_state_sdr,
    input  logic                         virtual_state_e1dr,
    input  logic                         virtual_state_pdr,
    input  logic                         virtual_state_e2dr,
    input  logic                         virtual_state_udr,
    input  logic                         virtual_state_cir,
    input  logic                         virtual_state_uir,
    output logic [NUM_REGS*DR_WIDTH-1:0] reg_q,
    input  logic [NUM_REGS*DR_WIDTH-1:0] reg_d,
    output logic [NUM_REGS-1:0]          wr_pulse,
    output logic [NUM_REGS-1:0]          rd_pulse
);

    localparam int CNT_W = $clog2(DR_WIDTH + 2);
    localparam int UPD_W = IR_WIDTH - 2;

    typedef enum logic [1:0] {IDLE, CAPT, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {DEC_BYPASS, DEC_IDCODE, DEC_USER, DEC_CLRERR} dec_t;

    state_t               state;
    dec_t                 dec;
    logic                 invalid_code;
    logic                 invalid_q;
    logic                 err;
    logic [UPD_W-1:0]     upd_cnt;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DR_WIDTH-1:0]  sr;
    logic [DR_WIDTH-1:0]  user_rd;
    logic [NUM_REGS-1:0]  user_hot;
    logic                 ro_hit;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        dec          = DEC_BYPASS;
        invalid_code = 1'b0;
        user_hot     = '0;
        if (ir_in == IR_WIDTH'(0)) begin
            dec = DEC_BYPASS;
        end else if (ir_in == IR_WIDTH'(1)) begin
            dec = DEC_IDCODE;
        end else if ((ir_in >> 4) == IR_WIDTH'(1) && int'(ir_in[3:0]) < NUM_REGS) begin
            dec      = DEC_USER;
            user_hot = NUM_REGS'(1) << ir_in[3:0];
        end else if (ir_in == IR_WIDTH'(9'h1FF)) begin
            dec = DEC_CLRERR;
        end else begin
            invalid_code = 1'b1;
        end

        user_rd = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (user_hot[k]) user_rd = user_rd | reg_d[k*DR_WIDTH +: DR_WIDTH];
        end
    end

    assign ro_hit   = |(user_hot & RO_MASK);
    assign tdo      = sr[0];
    // The read strobe marks the very cycle reg_d is sampled, so the source can pop or clear on it.
    assign rd_pulse = (virtual_state_cdr && !reset) ? user_hot : '0;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge tck) begin
        if (reset) begin
            // NOTE: reg_q is a handful of flops rather than a RAM, so it is cleared with the rest.
            state     <= IDLE;
            sr        <= '0;
            bit_cnt   <= '0;
            reg_q     <= '0;
            wr_pulse  <= '0;
            err       <= 1'b0;
            upd_cnt   <= '0;
            invalid_q <= 1'b0;
            ir_out    <= '0;
        end else begin
            wr_pulse <= '0;
            if (virtual_state_uir) invalid_q <= invalid_code;
            if (virtual_state_cir) ir_out <= {err, invalid_q, upd_cnt};

            if (virtual_state_cdr) begin
                state   <= CAPT;
                bit_cnt <= '0;
                case (dec)
                    DEC_USER:   sr <= user_rd;
                    DEC_IDCODE: sr <= DR_WIDTH'(ID_VALUE);
                    default:    sr <= '0;
                endcase
            end else if (virtual_state_udr) begin
                // udr beats a coincident sdr, so the shift register is left untouched here.
                state <= IDLE;
                if (dec == DEC_USER) begin
                    if (bit_cnt == CNT_W'(DR_WIDTH) && !ro_hit) begin
                        for (int k = 0; k < NUM_REGS; k++) begin
                            if (user_hot[k]) reg_q[k*DR_WIDTH +: DR_WIDTH] <= sr;
                        end
                        wr_pulse <= user_hot;
                        upd_cnt  <= upd_cnt + 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                end else if (dec == DEC_CLRERR) begin
                    err <= 1'b0;
                end
            end else if (virtual_state_sdr && state != IDLE) begin
                state <= SHIFT;
                if (bit_cnt != CNT_W'(DR_WIDTH + 1)) bit_cnt <= bit_cnt + 1'b1;
                if (dec == DEC_USER || dec == DEC_IDCODE) sr <= {tdi, sr[DR_WIDTH-1:1]};
                else                                      sr[0] <= tdi;
            end else if ((virtual_state_e1dr || virtual_state_pdr || virtual_state_e2dr)
                         && state != IDLE) begin
                state <= DONE;
            end
        end
    end

endmodule

// File: tb/tb_jtag_dr_bank.sv
// Self-checking bench for jtag_dr_bank: directed scenarios pinned by literal values, then
// randomized DR transactions compared every cycle against a behavioural register-bank model.
module tb_jtag_dr_bank;

    localparam int          IRW = 9;
    localparam int          DRW = 32;
    localparam int          NR  = 4;
    localparam logic [3:0]  RO  = 4'b1000;
    localparam logic [31:0] IDV = 32'h4A54_0001;

    logic           tck = 1'b0;
    logic           reset, tdi, tdo;
    logic [IRW-1:0] ir_in, ir_out;
    logic           cdr, sdr, e1dr, pdr, e2dr, udr, cir, uir;
    logic [NR*DRW-1:0] reg_q, reg_d;
    logic [NR-1:0]  wr_pulse, rd_pulse;

    jtag_dr_bank #(
        .IR_WIDTH(IRW), .DR_WIDTH(DRW), .NUM_REGS(NR), .RO_MASK(RO), .ID_VALUE(IDV)
    ) dut (
        .tck(tck), .reset(reset), .tdi(tdi), .tdo(tdo),
        .ir_in(ir_in), .ir_out(ir_out),
        .virtual_state_cdr(cdr), .virtual_state_sdr(sdr), .virtual_state_e1dr(e1dr),
        .virtual_state_pdr(pdr), .virtual_state_e2dr(e2dr), .virtual_state_udr(udr),
        .virtual_state_cir(cir), .virtual_state_uir(uir),
        .reg_q(reg_q), .reg_d(reg_d), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
    );

    always #5 tck = ~tck;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // kind: 0 bypass, 1 idcode, 2 user, 3 clrerr, 4 undefined
    function automatic int kind_of(input logic [IRW-1:0] ir);
        if (ir == 0) return 0;
        if (ir == 1) return 1;
        if (ir >= 16 && ir < 16 + NR) return 2;
        if (ir == 9'h1FF) return 3;
        return 4;
    endfunction

    bit          started = 0;
    logic [31:0] m_sr;
    int          m_cnt;
    bit          m_live;
    logic [31:0] m_reg [NR];
    int          m_wr;
    bit          m_err, m_inv;
    int          m_upd;
    logic [8:0]  m_irout;

    always @(posedge tck) begin
        int kd, k;
        if (reset) begin
            started = 1;
            m_sr = 0; m_cnt = 0; m_live = 0; m_wr = -1;
            m_err = 0; m_inv = 0; m_upd = 0; m_irout = 0;
            for (int i = 0; i < NR; i++) m_reg[i] = 0;
        end else begin
            kd = kind_of(ir_in);
            k  = int'(ir_in) - 16;
            m_wr = -1;
            if (cir) m_irout = {m_err, m_inv, 7'(m_upd)};
            if (uir) m_inv = (kd == 4);
            if (cdr) begin
                m_live = 1;
                m_cnt  = 0;
                m_sr   = (kd == 2) ? reg_d[k*DRW +: DRW] : (kd == 1) ? IDV : 32'd0;
            end else if (udr) begin
                m_live = 0;
                if (kd == 2) begin
                    if (m_cnt == DRW && !RO[k]) begin
                        m_reg[k] = m_sr;
                        m_wr     = k;
                        m_upd    = (m_upd + 1) % 128;
                    end else begin
                        m_err = 1;
                    end
                end else if (kd == 3) begin
                    m_err = 0;
                end
            end else if (sdr && m_live) begin
                if (m_cnt < DRW + 1) m_cnt++;
                if (kd == 1 || kd == 2) m_sr = (m_sr >> 1) | (32'(tdi) << 31);
                else                    m_sr[0] = tdi;
            end
        end
    end

    always @(negedge tck) begin
        logic [NR*DRW-1:0] exp_q;
        logic [NR-1:0]     exp_rd;
        if (started) begin
            for (int i = 0; i < NR; i++) exp_q[i*DRW +: DRW] = m_reg[i];
            exp_rd = (!reset && cdr && kind_of(ir_in) == 2) ? NR'(1) << (int'(ir_in) - 16) : '0;
            check("tdo", tdo, m_sr[0]);
            check("reg_q", reg_q, exp_q);
            check("wr_pulse", wr_pulse, (m_wr >= 0) ? NR'(1) << m_wr : NR'(0));
            check("rd_pulse", rd_pulse, exp_rd);
            check("ir_out", ir_out, m_irout);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    task automatic set_ir(input logic [IRW-1:0] v);
        ir_in = v; uir = 1; tick(); uir = 0;
    endtask

    task automatic capture();
        cdr = 1; tick(); cdr = 0;
    endtask

    task automatic update();
        udr = 1; tick(); udr = 0;
    endtask

    task automatic cap_ir(output logic [IRW-1:0] o);
        cir = 1; tick(); cir = 0; o = ir_out;
    endtask

    // Reads tdo ahead of each shift edge, so o collects the captured word LSB first.
    task automatic shift_word(input logic [31:0] w, input int n, output logic [31:0] o);
        o = '0;
        for (int i = 0; i < n; i++) begin
            o[i] = tdo;
            tdi = w[i]; sdr = 1; tick(); sdr = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0]    o;
        logic [IRW-1:0] irv;
        logic           b;
        int             n;

        reset = 1; tdi = 0; ir_in = 0; reg_d = '0;
        cdr = 0; sdr = 0; e1dr = 0; pdr = 0; e2dr = 0; udr = 0; cir = 0; uir = 0;
        tick(); tick();
        check("reset_reg_q", reg_q, '0);
        check("reset_tdo", tdo, 1'b0);
        check("reset_ir_out", ir_out, '0);
        reset = 0;
        tick();

        // IDCODE readout
        set_ir(9'h001); capture();
        shift_word(32'h0, 32, o);
        check("idcode_tdo", o, 32'h4A54_0001);

        // full write to user 2
        set_ir(9'h012); capture();
        shift_word(32'hDEAD_BEEF, 32, o);
        update();
        check("user2_reg_q", reg_q[2*DRW +: DRW], 32'hDEAD_BEEF);
        check("user2_wr_pulse", wr_pulse, 4'b0100);
        tick();
        check("user2_wr_pulse_end", wr_pulse, 4'b0000);
        cap_ir(irv);
        check("upd_cnt_one", irv[6:0], 7'd1);

        // readback of user 1
        set_ir(9'h011);
        reg_d[1*DRW +: DRW] = 32'h1234_5678;
        cdr = 1; tick();
        check("user1_rd_pulse", rd_pulse, 4'b0010);
        cdr = 0;
        shift_word(32'h0, 32, o);
        check("user1_readback", o, 32'h1234_5678);

        // partial shift sets err, CLRERR clears it
        set_ir(9'h010); capture();
        shift_word(32'hFFFF_FFFF, 31, o);
        update();
        check("short_no_write", reg_q[31:0], 32'h0);
        check("short_no_pulse", wr_pulse, 4'b0000);
        cap_ir(irv);
        check("short_err_set", irv[8], 1'b1);
        set_ir(9'h1FF); update();
        cap_ir(irv);
        check("clrerr", irv[8], 1'b0);

        // read-only register and undefined instruction
        set_ir(9'h013); capture();
        shift_word(32'hA5A5_A5A5, 32, o);
        update();
        check("ro_no_write", reg_q[3*DRW +: DRW], 32'h0);
        check("ro_no_pulse", wr_pulse, 4'b0000);
        cap_ir(irv);
        check("ro_err", irv[8], 1'b1);
        set_ir(9'h055); capture();
        for (int i = 0; i < 8; i++) begin
            b = 1'($urandom);
            tdi = b; sdr = 1; tick(); sdr = 0;
            check("bypass_tdo", tdo, b);
        end
        cap_ir(irv);
        check("invalid_flag", irv[7], 1'b1);

        // reset in the middle of a user shift
        set_ir(9'h011); capture();
        shift_word(32'h0, 9, o);
        tdi = 1; sdr = 1; reset = 1; tick(); reset = 0; sdr = 0;
        check("midreset_reg_q", reg_q, '0);
        check("midreset_pulse", wr_pulse, 4'b0000);
        check("midreset_tdo", tdo, 1'b0);
        capture();
        shift_word(32'hCAFE_F00D, 32, o);
        update();
        check("postreset_write", reg_q[1*DRW +: DRW], 32'hCAFE_F00D);
        check("postreset_pulse", wr_pulse, 4'b0010);

        // randomized transactions
        for (int t = 0; t < 250; t++) begin
            case ($urandom_range(0, 9))
                0:       irv = 9'h000;
                1:       irv = 9'h001;
                2, 3, 4: irv = 9'(16 + $urandom_range(0, NR - 1));
                5:       irv = 9'h1FF;
                6:       irv = 9'($urandom);
                default: irv = 9'(16 + $urandom_range(0, NR - 1));
            endcase
            set_ir(irv);
            reg_d = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 9) != 0) capture();
            n = ($urandom_range(0, 1) == 1) ? 32 : $urandom_range(0, 36);
            for (int i = 0; i < n; i++) begin
                tdi = 1'($urandom); sdr = 1;
                if ($urandom_range(0, 99) == 0) reset = 1;
                tick(); sdr = 0; reset = 0;
                if ($urandom_range(0, 19) == 0) begin
                    e1dr = 1; tick(); e1dr = 0;
                    pdr  = 1; tick(); pdr  = 0;
                    e2dr = 1; tick(); e2dr = 0;
                end
            end
            tdi = 1'($urandom);
            sdr = ($urandom_range(0, 9) == 0);
            update();
            sdr = 0;
            if ($urandom_range(0, 1) == 1) cap_ir(irv);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
